// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for core_mem; MEM_RPORTS sets the default read-port count
`ifndef MEM_RPORTS
`define MEM_RPORTS 2
`endif

package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic  val;
    logic  wen;
    addr_t addr;
    word_t wdata;
  } mem_req_t;

  typedef enum logic {IDLE, ISSUED} port_state_e;

  // Low address bits pick the bank so sequential fetches spread across banks.
  function automatic addr_t bank_of(addr_t addr, int nbanks);
    return addr & addr_t'(nbanks - 1);
  endfunction
endpackage

// File: rtl/core_mem_bank.sv
// rtl/core_mem_bank.sv - one single-port RAM bank with fixed-priority + round-robin requester arbiter
module core_mem_bank
  import mem_pkg::*;
#(
  parameter int NBANKS = 2,
  parameter int NRD    = 2,
  parameter int NHP    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  mem_req_t [NRD-1:0]  rd_req_i,
  input  mem_req_t [NHP-1:0]  hp_req_i,
  output logic     [NRD-1:0]  rd_gnt_o,
  output logic     [NHP-1:0]  hp_gnt_o,
  output word_t               rdata_o
);
  localparam int BANK_W = $clog2(NBANKS);
  localparam int IDX_W  = ADDR_W - BANK_W;
  localparam int PTR_W  = (NRD > 1) ? $clog2(NRD) : 1;

  word_t            mem [2**IDX_W];
  logic [PTR_W-1:0] ptr_q;
  word_t            rdata_q;
  mem_req_t         sel;
  logic [IDX_W-1:0] idx;
  logic             rd_won;
  int               best;
  int               win;

  always_comb begin
    hp_gnt_o = '0;
    rd_gnt_o = '0;
    sel      = '0;
    best     = NRD;
    win      = 0;
    // Descending scan leaves the lowest index (highest priority) as the winner.
    for (int i = NHP - 1; i >= 0; i--) begin
      if (hp_req_i[i].val) begin
        hp_gnt_o    = '0;
        hp_gnt_o[i] = 1'b1;
        sel         = hp_req_i[i];
      end
    end
    for (int i = 0; i < NRD; i++) begin
      if (rd_req_i[i].val && ((i + NRD - int'(ptr_q)) % NRD) < best) begin
        best = (i + NRD - int'(ptr_q)) % NRD;
        win  = i;
      end
    end
    rd_won = (hp_gnt_o == '0) && (best < NRD);
    for (int i = 0; i < NRD; i++) begin
      rd_gnt_o[i] = rd_won && (i == win);
      if (rd_won && (i == win)) sel = rd_req_i[i];
    end
  end

  assign idx     = IDX_W'(sel.addr >> BANK_W);
  assign rdata_o = rdata_q;

  // RAM has no reset path: a write granted during reset still lands.
  always_ff @(posedge clk_i) begin
    if (sel.val && sel.wen) mem[idx] <= sel.wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (sel.val) rdata_q <= sel.wen ? sel.wdata : mem[idx];
      if (rd_won) ptr_q <= PTR_W'((win + 1) % NRD);
    end
  end
endmodule

// File: rtl/core_mem.sv
// rtl/core_mem.sv - banked TOY main memory responder for fetch and LSU ports; CORE_MEM_DBG_EN adds a debug port
module core_mem
  import mem_pkg::*;
#(
  parameter int NRPORTS = `MEM_RPORTS,
  parameter int NBANKS  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NRPORTS-1:0]             r_val_i,
  input  logic [NRPORTS-1:0][ADDR_W-1:0] r_addr_i,
  output logic [NRPORTS-1:0]             r_rdy_o,
  output logic [NRPORTS-1:0][DATA_W-1:0] r_rdata_o,
  input  logic                           rw_val_i,
  input  logic                           rw_wen_i,
  input  logic [ADDR_W-1:0]              rw_addr_i,
  input  logic [DATA_W-1:0]              rw_wdata_i,
  output logic                           rw_rdy_o,
  output logic [DATA_W-1:0]              rw_rdata_o
`ifdef CORE_MEM_DBG_EN
  ,
  input  logic                           dbg_val_i,
  input  logic                           dbg_wen_i,
  input  logic [ADDR_W-1:0]              dbg_addr_i,
  input  logic [DATA_W-1:0]              dbg_wdata_i,
  output logic                           dbg_rdy_o,
  output logic [DATA_W-1:0]              dbg_rdata_o
`endif
);
`ifdef CORE_MEM_DBG_EN
  localparam int NHP = 2;
`else
  localparam int NHP = 1;
`endif
  localparam int NP = NRPORTS + NHP;

  mem_req_t [NP-1:0]              req;
  mem_req_t [NBANKS-1:0][NP-1:0]  bank_req;
  logic     [NBANKS-1:0][NP-1:0]  gnt;
  word_t    [NBANKS-1:0]          bank_rdata;
  logic     [NP-1:0]              elig, granted, rdy;
  word_t    [NP-1:0]              rdata;
  port_state_e                    state_q [NP];
  mem_req_t                       cap_q   [NP];

  // Port order: read ports, then debug (if present), then rw last.
  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      req[p] = '{val: r_val_i[p], wen: 1'b0, addr: r_addr_i[p], wdata: word_t'(0)};
    end
    req[NP-1] = '{val: rw_val_i, wen: rw_wen_i, addr: rw_addr_i, wdata: rw_wdata_i};
`ifdef CORE_MEM_DBG_EN
    req[NRPORTS] = '{val: dbg_val_i, wen: dbg_wen_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
`endif
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rdy[p]     = rst_ni && (state_q[p] == ISSUED) && req[p].val && (req[p] == cap_q[p]);
      elig[p]    = req[p].val && !((state_q[p] == ISSUED) && (req[p] == cap_q[p]));
      granted[p] = 1'b0;
      rdata[p]   = '0;
      for (int b = 0; b < NBANKS; b++) begin
        bank_req[b][p]     = req[p];
        bank_req[b][p].val = elig[p] && (bank_of(req[p].addr, NBANKS) == addr_t'(b));
        granted[p]         = granted[p] | gnt[b][p];
        if (rdy[p] && (bank_of(cap_q[p].addr, NBANKS) == addr_t'(b))) rdata[p] = bank_rdata[b];
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    core_mem_bank #(
      .NBANKS (NBANKS),
      .NRD    (NRPORTS),
      .NHP    (NHP)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rd_req_i (bank_req[b][NRPORTS-1:0]),
      .hp_req_i (bank_req[b][NP-1:NRPORTS]),
      .rd_gnt_o (gnt[b][NRPORTS-1:0]),
      .hp_gnt_o (gnt[b][NP-1:NRPORTS]),
      .rdata_o  (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) begin
      if (!rst_ni) begin
        state_q[p] <= IDLE;
        cap_q[p]   <= '0;
      end else if (granted[p]) begin
        state_q[p] <= ISSUED;
        cap_q[p]   <= req[p];
      end else begin
        state_q[p] <= IDLE;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      r_rdy_o[p]   = rdy[p];
      r_rdata_o[p] = rdata[p];
    end
  end

  assign rw_rdy_o   = rdy[NP-1];
  assign rw_rdata_o = rdata[NP-1];
`ifdef CORE_MEM_DBG_EN
  assign dbg_rdy_o   = rdy[NRPORTS];
  assign dbg_rdata_o = rdata[NRPORTS];
`endif
endmodule

// File: tb/tb_core_mem.sv
// tb/tb_core_mem.sv - directed self-checking bench for core_mem (debug port tested when CORE_MEM_DBG_EN is set)
`ifndef MEM_RPORTS
`define MEM_RPORTS 2
`endif

module tb_core_mem;
  localparam int NR = `MEM_RPORTS;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0]        r_val_i;
  logic [NR-1:0][7:0]   r_addr_i;
  logic [NR-1:0]        r_rdy_o;
  logic [NR-1:0][15:0]  r_rdata_o;
  logic                 rw_val_i, rw_wen_i;
  logic [7:0]           rw_addr_i;
  logic [15:0]          rw_wdata_i;
  logic                 rw_rdy_o;
  logic [15:0]          rw_rdata_o;
`ifdef CORE_MEM_DBG_EN
  logic                 dbg_val_i, dbg_wen_i;
  logic [7:0]           dbg_addr_i;
  logic [15:0]          dbg_wdata_i;
  logic                 dbg_rdy_o;
  logic [15:0]          dbg_rdata_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  core_mem #(.NRPORTS(NR), .NBANKS(2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .r_val_i    (r_val_i),
    .r_addr_i   (r_addr_i),
    .r_rdy_o    (r_rdy_o),
    .r_rdata_o  (r_rdata_o),
    .rw_val_i   (rw_val_i),
    .rw_wen_i   (rw_wen_i),
    .rw_addr_i  (rw_addr_i),
    .rw_wdata_i (rw_wdata_i),
    .rw_rdy_o   (rw_rdy_o),
    .rw_rdata_o (rw_rdata_o)
`ifdef CORE_MEM_DBG_EN
    ,
    .dbg_val_i   (dbg_val_i),
    .dbg_wen_i   (dbg_wen_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_rdy_o   (dbg_rdy_o),
    .dbg_rdata_o (dbg_rdata_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    r_val_i = '0; r_addr_i = '0;
    rw_val_i = 1'b0; rw_wen_i = 1'b0; rw_addr_i = '0; rw_wdata_i = '0;
`ifdef CORE_MEM_DBG_EN
    dbg_val_i = 1'b0; dbg_wen_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
`endif
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
    tick();
    rw_val_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = a; rw_wdata_i = d;
    tick();
    rw_val_i = 1'b0; rw_wen_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++; if (r_rdy_o !== 2'b00) begin errors++; $display("FAIL reset_r_rdy got %b exp 00", r_rdy_o); end
    checks++; if (rw_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rw_rdy got %b exp 0", rw_rdy_o); end
    checks++; if (r_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_r_rdata got %h exp 0", r_rdata_o); end
    checks++; if (rw_rdata_o !== 16'h0) begin errors++; $display("FAIL reset_rw_rdata got %h exp 0", rw_rdata_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    tick();
    r_val_i[0] = 1'b1; r_addr_i[0] = 8'h10;
    #1;
    checks++; if (r_rdy_o[0] !== 1'b0) begin errors++; $display("FAIL single_n_rdy got %b exp 0", r_rdy_o[0]); end
    tick();
    checks++; if (r_rdy_o[0] !== 1'b1) begin errors++; $display("FAIL single_n1_rdy got %b exp 1", r_rdy_o[0]); end
    checks++; if (r_rdata_o[0] !== 16'h1234) begin errors++; $display("FAIL single_rdata got %h exp 1234", r_rdata_o[0]); end
    tick();
    r_val_i = '0;
  endtask

  task automatic test_parallel_banks();
    tick();
    r_val_i = 2'b11; r_addr_i[0] = 8'h10; r_addr_i[1] = 8'h11;
    #1;
    checks++; if (r_rdy_o !== 2'b00) begin errors++; $display("FAIL par_n_rdy got %b exp 00", r_rdy_o); end
    tick();
    checks++; if (r_rdy_o !== 2'b11) begin errors++; $display("FAIL par_n1_rdy got %b exp 11", r_rdy_o); end
    checks++; if (r_rdata_o[0] !== 16'h1234) begin errors++; $display("FAIL par_rdata0 got %h exp 1234", r_rdata_o[0]); end
    checks++; if (r_rdata_o[1] !== 16'h5678) begin errors++; $display("FAIL par_rdata1 got %h exp 5678", r_rdata_o[1]); end
    tick();
    r_val_i = '0;
  endtask

  task automatic test_same_bank_rr();
    do_reset();
    tick();
    r_val_i = 2'b11; r_addr_i[0] = 8'h10; r_addr_i[1] = 8'h12;
    #1;
    checks++; if (r_rdy_o !== 2'b00) begin errors++; $display("FAIL rr_n_rdy got %b exp 00", r_rdy_o); end
    tick();
    checks++; if (r_rdy_o !== 2'b01) begin errors++; $display("FAIL rr_n1_rdy got %b exp 01", r_rdy_o); end
    checks++; if (r_rdata_o[0] !== 16'h1234) begin errors++; $display("FAIL rr_n1_rdata0 got %h exp 1234", r_rdata_o[0]); end
    tick();
    r_val_i[0] = 1'b0;
    #1;
    checks++; if (r_rdy_o !== 2'b10) begin errors++; $display("FAIL rr_n2_rdy got %b exp 10", r_rdy_o); end
    checks++; if (r_rdata_o[1] !== 16'h9abc) begin errors++; $display("FAIL rr_n2_rdata1 got %h exp 9abc", r_rdata_o[1]); end
    // r0 alone moves the pointer to r1, so the next contended pair serves r1 first
    tick();
    r_val_i = 2'b01;
    tick();
    tick();
    r_val_i = 2'b11;
    #1;
    tick();
    checks++; if (r_rdy_o !== 2'b10) begin errors++; $display("FAIL rr_rep_first got %b exp 10", r_rdy_o); end
    checks++; if (r_rdata_o[1] !== 16'h9abc) begin errors++; $display("FAIL rr_rep_rdata1 got %h exp 9abc", r_rdata_o[1]); end
    tick();
    r_val_i[1] = 1'b0;
    #1;
    checks++; if (r_rdy_o !== 2'b01) begin errors++; $display("FAIL rr_rep_second got %b exp 01", r_rdy_o); end
    tick();
    r_val_i = '0;
  endtask

  task automatic test_write_then_read();
    tick();
    rw_val_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = 8'h20; rw_wdata_i = 16'hbeef;
    r_val_i[0] = 1'b1; r_addr_i[0] = 8'h20;
    #1;
    checks++; if ({rw_rdy_o, r_rdy_o[0]} !== 2'b00) begin errors++; $display("FAIL wr_n_rdy got %b exp 00", {rw_rdy_o, r_rdy_o[0]}); end
    tick();
    checks++; if ({rw_rdy_o, r_rdy_o[0]} !== 2'b10) begin errors++; $display("FAIL wr_n1_rdy got %b exp 10", {rw_rdy_o, r_rdy_o[0]}); end
    checks++; if (rw_rdata_o !== 16'hbeef) begin errors++; $display("FAIL wr_echo got %h exp beef", rw_rdata_o); end
    tick();
    rw_val_i = 1'b0; rw_wen_i = 1'b0;
    #1;
    checks++; if (r_rdy_o[0] !== 1'b1) begin errors++; $display("FAIL wr_n2_rdy got %b exp 1", r_rdy_o[0]); end
    checks++; if (r_rdata_o[0] !== 16'hbeef) begin errors++; $display("FAIL wr_n2_rdata got %h exp beef", r_rdata_o[0]); end
    tick();
    r_val_i = '0;
  endtask

  task automatic test_abandon();
    tick();
    r_val_i[0] = 1'b1; r_addr_i[0] = 8'h10;
    tick();
    r_addr_i[0] = 8'h30;
    #1;
    checks++; if (r_rdy_o[0] !== 1'b0) begin errors++; $display("FAIL ab_n1_rdy got %b exp 0", r_rdy_o[0]); end
    tick();
    checks++; if (r_rdy_o[0] !== 1'b1) begin errors++; $display("FAIL ab_n2_rdy got %b exp 1", r_rdy_o[0]); end
    checks++; if (r_rdata_o[0] !== 16'hcafe) begin errors++; $display("FAIL ab_n2_rdata got %h exp cafe", r_rdata_o[0]); end
    tick();
    r_val_i = '0;
  endtask

  task automatic test_reset_midop();
    tick();
    r_val_i[0] = 1'b1; r_addr_i[0] = 8'h10;
    tick();
    rst_ni = 1'b0;
    rw_val_i = 1'b1; rw_wen_i = 1'b1; rw_addr_i = 8'h22; rw_wdata_i = 16'h7777;
    #1;
    checks++; if ({rw_rdy_o, r_rdy_o} !== 3'b000) begin errors++; $display("FAIL rst_n1_rdy got %b exp 000", {rw_rdy_o, r_rdy_o}); end
    tick();
    rw_val_i = 1'b0; rw_wen_i = 1'b0;
    #1;
    checks++; if ({rw_rdy_o, r_rdy_o} !== 3'b000) begin errors++; $display("FAIL rst_n2_rdy got %b exp 000", {rw_rdy_o, r_rdy_o}); end
    tick();
    rst_ni = 1'b1; r_val_i = '0;
    tick();
    r_val_i[0] = 1'b1; r_addr_i[0] = 8'h20;
    tick();
    checks++; if (r_rdy_o[0] !== 1'b1 || r_rdata_o[0] !== 16'hbeef) begin errors++; $display("FAIL rst_keep_20 got %b/%h exp 1/beef", r_rdy_o[0], r_rdata_o[0]); end
    r_addr_i[0] = 8'h22;
    tick();
    checks++; if (r_rdy_o[0] !== 1'b1 || r_rdata_o[0] !== 16'h7777) begin errors++; $display("FAIL rst_write_22 got %b/%h exp 1/7777", r_rdy_o[0], r_rdata_o[0]); end
    tick();
    r_val_i = '0;
  endtask

`ifdef CORE_MEM_DBG_EN
  task automatic test_dbg_priority();
    tick();
    dbg_val_i = 1'b1; dbg_wen_i = 1'b1; dbg_addr_i = 8'h40; dbg_wdata_i = 16'h00ff;
    rw_val_i = 1'b1; rw_wen_i = 1'b0; rw_addr_i = 8'h40;
    #1;
    checks++; if ({dbg_rdy_o, rw_rdy_o} !== 2'b00) begin errors++; $display("FAIL dbg_n_rdy got %b exp 00", {dbg_rdy_o, rw_rdy_o}); end
    tick();
    checks++; if ({dbg_rdy_o, rw_rdy_o} !== 2'b10 || dbg_rdata_o !== 16'h00ff) begin errors++; $display("FAIL dbg_n1 got %b/%h exp 10/00ff", {dbg_rdy_o, rw_rdy_o}, dbg_rdata_o); end
    tick();
    dbg_val_i = 1'b0; dbg_wen_i = 1'b0;
    #1;
    checks++; if (rw_rdy_o !== 1'b1 || rw_rdata_o !== 16'h00ff) begin errors++; $display("FAIL dbg_rw_n2 got %b/%h exp 1/00ff", rw_rdy_o, rw_rdata_o); end
    tick();
    rw_val_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    mem_write(8'h10, 16'h1234);
    mem_write(8'h11, 16'h5678);
    mem_write(8'h12, 16'h9abc);
    mem_write(8'h30, 16'hcafe);
    tick();
    test_single_read();
    test_parallel_banks();
    test_same_bank_rr();
    test_write_then_read();
    test_abandon();
    test_reset_midop();
`ifdef CORE_MEM_DBG_EN
    test_dbg_priority();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
